telemetry_tx: RTL and testbench



---
 rtl/telemetry_tx_if.sv | 39 +++
 rtl/telemetry_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_telemetry_tx.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : telemetry_tx_if
// Description : Sample bus feeding the telemetry transmitter. Carries the
//               end-of-conversion strobe together with the ADC pair and the
//               controller duty outputs that are valid on that strobe.
//                 sample_valid : one-cycle pulse, new sample set valid
//                 vfc          : flying-cap voltage, unsigned 16 bit
//                 vout         : output voltage, unsigned 16 bit
//                 d1, d2       : duty values, 7 bit
//               master drives the bus (ADC/controller side), slave consumes
//               it (telemetry transmitter).
// Revision    : 1.0  initial release
// ============================================================================
interface telemetry_tx_if;
    logic        sample_valid;
    logic [15:0] vfc;
    logic [15:0] vout;
    logic [6:0]  d1;
    logic [6:0]  d2;

    modport master (
        output sample_valid,
        output vfc,
        output vout,
        output d1,
        output d2
    );

    modport slave (
        input sample_valid,
        input vfc,
        input vout,
        input d1,
        input d2
    );
endinterface
`default_nettype wire

// File: rtl/telemetry_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : telemetry_tx
// Description : Decimating telemetry snapshot transmitter. Every DECIMATION-th
//               sample strobe latches vfc, vout, d1 and d2 and sends them as a
//               10-byte framed, checksummed 8N1 UART frame:
//                 A5 5A vfc_hi vfc_lo vout_hi vout_lo {0,d1} {0,d2} seq xor
//               where xor covers bytes 2..8. Snapshots that arrive while a
//               frame is in flight are dropped (never back-pressures) and
//               counted with a saturating 16-bit counter.
// Ports       : clk_i         system clock
//               rst_ni        asynchronous active-low reset
//               smp           sample bus (slave modport)
//               tx_o          UART TX line, idle high
//               busy_o        high while a frame is being sent
//               drop_o        one-cycle pulse per discarded snapshot
//               drop_count_o  saturating count of discarded snapshots
// Revision    : 1.0  initial release
// ============================================================================
module telemetry_tx #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DECIMATION = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    telemetry_tx_if.slave     smp,
    output logic              tx_o,
    output logic              busy_o,
    output logic              drop_o,
    output logic [15:0]       drop_count_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_clks_per_bit = CLK_FREQ / BAUD_RATE;
    localparam int c_tw           = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam logic [c_tw-1:0] c_last_clk   = c_tw'(c_clks_per_bit - 1);
    localparam logic [15:0]     c_dec_last   = 16'(DECIMATION - 1);
    localparam logic [3:0]      c_last_byte  = 4'd9;
    localparam logic [2:0]      c_last_bit   = 3'd7;
    localparam logic [7:0]      c_sync0      = 8'hA5;
    localparam logic [7:0]      c_sync1      = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [15:0]      r_dec_cnt;
    logic [c_tw-1:0]  r_timer;      // clocks elapsed within current bit
    logic [2:0]       r_bit_idx;    // data bit index within current byte
    logic [3:0]       r_byte_idx;   // byte index within frame
    logic [7:0]       r_shift;      // data byte being shifted out, LSB first
    logic [7:0]       r_seq;
    logic [15:0]      r_vfc;
    logic [15:0]      r_vout;
    logic [6:0]       r_d1;
    logic [6:0]       r_d2;
    logic [7:0]       r_csum;
    logic             r_tx;
    logic             r_busy;
    logic             r_drop;
    logic [15:0]      r_drop_count;

    logic             w_trig;
    logic             w_bit_end;
    logic [7:0]       w_csum;
    logic [7:0]       w_byte;

    // A trigger is the strobe that completes a decimation period.
    assign w_trig    = smp.sample_valid && (r_dec_cnt == c_dec_last);
    assign w_bit_end = (r_timer == c_last_clk);

    // Checksum depends only on latched snapshot and sequence number, both of
    // which are stable for the whole frame; registering it adds one cycle of
    // latency, which is far shorter than the nine bytes ahead of it.
    assign w_csum = r_vfc[15:8] ^ r_vfc[7:0] ^ r_vout[15:8] ^ r_vout[7:0]
                  ^ {1'b0, r_d1} ^ {1'b0, r_d2} ^ r_seq;

    // Byte to be sent at the current byte index.
    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx)
            4'd0:    w_byte = c_sync0;
            4'd1:    w_byte = c_sync1;
            4'd2:    w_byte = r_vfc[15:8];
            4'd3:    w_byte = r_vfc[7:0];
            4'd4:    w_byte = r_vout[15:8];
            4'd5:    w_byte = r_vout[7:0];
            4'd6:    w_byte = {1'b0, r_d1};
            4'd7:    w_byte = {1'b0, r_d2};
            4'd8:    w_byte = r_seq;
            4'd9:    w_byte = r_csum;
            default: w_byte = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------------
    // Decimation, drop accounting and UART framing state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_dec_cnt    <= 16'd0;
            r_timer      <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 4'd0;
            r_shift      <= 8'h00;
            r_seq        <= 8'h00;
            r_vfc        <= 16'h0000;
            r_vout       <= 16'h0000;
            r_d1         <= 7'h00;
            r_d2         <= 7'h00;
            r_csum       <= 8'h00;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_drop       <= 1'b0;
            r_drop_count <= 16'h0000;
        end else begin
            r_drop <= 1'b0;
            r_csum <= w_csum;

            if (smp.sample_valid) begin
                r_dec_cnt <= w_trig ? 16'd0 : r_dec_cnt + 16'd1;
            end

            // Any state other than IDLE is busy, including the final STOP
            // cycle on which busy_o falls, so a trigger there is dropped.
            if (w_trig && (r_state != S_IDLE)) begin
                r_drop <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_vfc      <= smp.vfc;
                        r_vout     <= smp.vout;
                        r_d1       <= smp.d1;
                        r_d2       <= smp.d2;
                        r_state    <= S_START;
                        r_busy     <= 1'b1;
                        r_tx       <= 1'b0;
                        r_timer    <= '0;
                        r_byte_idx <= 4'd0;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_state   <= S_DATA;
                        r_shift   <= w_byte;
                        r_tx      <= w_byte[0];
                        r_bit_idx <= 3'd0;
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_byte_idx == c_last_byte) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_byte_idx <= 4'd0;
                            r_seq      <= r_seq + 8'd1;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                            r_byte_idx <= r_byte_idx + 4'd1;
                        end
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign drop_o       = r_drop;
    assign drop_count_o = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_tx
// Description : Self-checking bench for telemetry_tx. Three instances run at
//               two clocks per bit: a DECIMATION=1 instance for frame content,
//               drops, sequence wrap and mid-frame reset; a DECIMATION=16
//               instance for decimation; and a DECIMATION=1 instance strobed
//               every cycle to drive the drop counter into saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_telemetry_tx;

    localparam int CLK_FREQ = 230400;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FCLK     = 100 * CPB;     // clocks per frame
    localparam int SAT_CYC  = 66000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_m, rst_n_d, rst_n_s;

    telemetry_tx_if bus_m ();
    telemetry_tx_if bus_d ();
    telemetry_tx_if bus_s ();

    logic        tx_m, busy_m, drop_m;
    logic [15:0] cnt_m;
    logic        tx_d, busy_d, drop_d;
    logic [15:0] cnt_d;
    logic        tx_s, busy_s, drop_s;
    logic [15:0] cnt_s;

    telemetry_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DECIMATION(1)) u_main (
        .clk_i(clk), .rst_ni(rst_n_m), .smp(bus_m),
        .tx_o(tx_m), .busy_o(busy_m), .drop_o(drop_m), .drop_count_o(cnt_m)
    );

    telemetry_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DECIMATION(16)) u_dec (
        .clk_i(clk), .rst_ni(rst_n_d), .smp(bus_d),
        .tx_o(tx_d), .busy_o(busy_d), .drop_o(drop_d), .drop_count_o(cnt_d)
    );

    telemetry_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DECIMATION(1)) u_sat (
        .clk_i(clk), .rst_ni(rst_n_s), .smp(bus_s),
        .tx_o(tx_s), .busy_o(busy_s), .drop_o(drop_s), .drop_count_o(cnt_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state for the main instance
    logic [7:0] exp_frame [10];
    int         m_seq   = 0;
    int         m_drops = 0;

    function automatic void build_frame(input logic [15:0] vfc, input logic [15:0] vout,
                                        input logic [6:0] d1, input logic [6:0] d2,
                                        input int seq);
        exp_frame[0] = 8'hA5;
        exp_frame[1] = 8'h5A;
        exp_frame[2] = vfc[15:8];
        exp_frame[3] = vfc[7:0];
        exp_frame[4] = vout[15:8];
        exp_frame[5] = vout[7:0];
        exp_frame[6] = {1'b0, d1};
        exp_frame[7] = {1'b0, d2};
        exp_frame[8] = 8'(seq);
        exp_frame[9] = 8'h00;
        for (int i = 2; i < 9; i++) exp_frame[9] = exp_frame[9] ^ exp_frame[i];
    endfunction

    // Strobe the main bus once; returns on the negedge after the strobed edge.
    // Inputs are scrambled afterwards so a frame relies on latched values.
    task automatic pulse_m(input logic [15:0] vfc, input logic [15:0] vout,
                           input logic [6:0] d1, input logic [6:0] d2);
        @(negedge clk);
        bus_m.sample_valid = 1'b1;
        bus_m.vfc  = vfc;
        bus_m.vout = vout;
        bus_m.d1   = d1;
        bus_m.d2   = d2;
        @(negedge clk);
        bus_m.sample_valid = 1'b0;
        bus_m.vfc  = 16'($urandom);
        bus_m.vout = 16'($urandom);
        bus_m.d1   = 7'($urandom);
        bus_m.d2   = 7'($urandom);
    endtask

    // Decode one frame from tx_m starting at the negedge right after the
    // triggering edge; every clock of every bit is sampled. With late set, a
    // strobe is placed on the edge at which busy must fall.
    task automatic recv_frame(input string tag, input bit late);
        logic [9:0] bits [10];
        logic [9:0] starts;
        logic [9:0] stops;
        int terr;
        int berr;
        int bp;
        terr = 0;
        berr = 0;
        for (int s = 0; s < FCLK; s++) begin
            if (s > 0) @(negedge clk);
            bp = s / CPB;
            if ((s % CPB) == 0) bits[bp / 10][bp % 10] = tx_m;
            else if (tx_m !== bits[bp / 10][bp % 10]) terr++;
            if (busy_m !== 1'b1) berr++;
            if (late && s == FCLK - 1) begin
                bus_m.sample_valid = 1'b1;
                bus_m.vfc = 16'($urandom);
            end
        end
        @(negedge clk);
        check({tag, "_busy_end"}, busy_m, 0);
        check({tag, "_tx_end"}, tx_m, 1);
        if (late) begin
            bus_m.sample_valid = 1'b0;
            m_drops++;
            check({tag, "_late_drop"}, drop_m, 1);
            check({tag, "_late_cnt"}, cnt_m, m_drops);
            @(negedge clk);
            check({tag, "_late_no_frame"}, busy_m, 0);
            check({tag, "_late_tx_idle"}, tx_m, 1);
            check({tag, "_late_drop_clr"}, drop_m, 0);
        end
        for (int b = 0; b < 10; b++) begin
            starts[b] = bits[b][0];
            stops[b]  = bits[b][9];
            check($sformatf("%s_byte%0d", tag, b), bits[b][8:1], exp_frame[b]);
        end
        check({tag, "_start_bits"}, starts, 10'h000);
        check({tag, "_stop_bits"}, stops, 10'h3FF);
        check({tag, "_bit_timing"}, terr, 0);
        check({tag, "_busy_len"}, berr, 0);
    endtask

    task automatic send_random(input string tag);
        logic [15:0] vfc, vout;
        logic [6:0]  d1, d2;
        vfc  = 16'($urandom);
        vout = 16'($urandom);
        d1   = 7'($urandom);
        d2   = 7'($urandom);
        build_frame(vfc, vout, d1, d2, m_seq);
        pulse_m(vfc, vout, d1, d2);
        recv_frame(tag, 1'b0);
        m_seq = (m_seq + 1) % 256;
    endtask

    // ------------------------------------------------------------------------
    // Main instance + decimation instance sequence
    // ------------------------------------------------------------------------
    task automatic main_thread();
        logic [15:0] vfc, vout;
        logic [6:0]  d1, d2;

        // Decimation = 16: fifteen strobes do nothing, the sixteenth starts
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus_d.sample_valid = 1'b1;
            bus_d.vfc  = 16'($urandom);
            bus_d.vout = 16'($urandom);
            @(negedge clk);
            bus_d.sample_valid = 1'b0;
            if (i < 16) begin
                if (tx_d !== 1'b1 || busy_d !== 1'b0) begin
                    check($sformatf("dec_idle_%0d", i), {tx_d, busy_d}, 2'b10);
                end
            end else begin
                check("dec16_tx_start", tx_d, 0);
                check("dec16_busy", busy_d, 1);
            end
        end
        check("dec15_tx_idle_before", 32'(n_err), 32'(n_err));
        repeat (FCLK - 1) @(negedge clk);
        check("dec_busy_last", busy_d, 1);
        @(negedge clk);
        check("dec_busy_fall", busy_d, 0);
        check("dec_tx_idle", tx_d, 1);
        check("dec_no_drop", cnt_d, 0);

        // Known vector
        build_frame(16'h6990, 16'h1234, 7'h40, 7'h20, m_seq);
        pulse_m(16'h6990, 16'h1234, 7'h40, 7'h20);
        recv_frame("known", 1'b0);
        m_seq = (m_seq + 1) % 256;

        // Drop while busy: frame in flight untouched
        vfc  = 16'($urandom);
        vout = 16'($urandom);
        d1   = 7'($urandom);
        d2   = 7'($urandom);
        build_frame(vfc, vout, d1, d2, m_seq);
        pulse_m(vfc, vout, d1, d2);
        fork
            recv_frame("dropfr", 1'b0);
            begin
                repeat (50) @(negedge clk);
                pulse_m(16'hFFFF, 16'hFFFF, 7'h7F, 7'h7F);
                m_drops++;
                check("drop_pulse", drop_m, 1);
                check("drop_cnt", cnt_m, m_drops);
                @(negedge clk);
                check("drop_pulse_clr", drop_m, 0);
            end
        join
        m_seq = (m_seq + 1) % 256;

        // Strobe on the very edge busy falls is dropped
        vfc  = 16'($urandom);
        vout = 16'($urandom);
        d1   = 7'($urandom);
        d2   = 7'($urandom);
        build_frame(vfc, vout, d1, d2, m_seq);
        pulse_m(vfc, vout, d1, d2);
        recv_frame("edge", 1'b1);
        m_seq = (m_seq + 1) % 256;

        // Random frames across the sequence wrap
        for (int f = 0; f < 258; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_random($sformatf("f%0d", f));
        end

        // Reset during a data bit of byte 4 (vout_hi bit 2 forced to 0)
        vfc  = 16'($urandom);
        vout = 16'($urandom) & 16'hFBFF;
        d1   = 7'($urandom);
        d2   = 7'($urandom);
        pulse_m(vfc, vout, d1, d2);
        repeat (43 * CPB) @(negedge clk);
        check("pre_rst_busy", busy_m, 1);
        check("pre_rst_tx_low", tx_m, 0);
        #2;
        rst_n_m = 1'b0;
        #1;
        check("rst_tx", tx_m, 1);
        check("rst_busy", busy_m, 0);
        check("rst_drop", drop_m, 0);
        check("rst_cnt", cnt_m, 0);
        @(negedge clk);
        rst_n_m = 1'b1;
        m_seq   = 0;
        m_drops = 0;
        repeat (3) @(negedge clk);
        check("post_rst_tx_idle", tx_m, 1);
        send_random("after_rst");
    endtask

    // ------------------------------------------------------------------------
    // Saturation instance: strobed every cycle, rule-based busy/drop model
    // ------------------------------------------------------------------------
    task automatic sat_thread();
        int  busy_end;
        int  drops;
        bit  exp_drop;
        busy_end = -1;
        drops    = 0;
        @(negedge clk);
        bus_s.sample_valid = 1'b1;
        bus_s.vfc  = 16'($urandom);
        bus_s.vout = 16'($urandom);
        for (int t = 0; t < SAT_CYC; t++) begin
            @(negedge clk);
            // A frame accepted at edge a occupies edges a..a+FCLK inclusive.
            if (busy_end >= 0 && t <= busy_end) begin
                exp_drop = 1'b1;
                drops++;
            end else begin
                exp_drop = 1'b0;
                busy_end = t + FCLK;
            end
            check("sat_drop", drop_s, exp_drop);
            check("sat_busy", busy_s, (t < busy_end) ? 1 : 0);
            check("sat_cnt", cnt_s, (drops > 65535) ? 65535 : drops);
        end
        bus_s.sample_valid = 1'b0;
        check("sat_final", cnt_s, 16'hFFFF);
    endtask

    initial begin
        bus_m.sample_valid = 1'b0; bus_m.vfc = '0; bus_m.vout = '0; bus_m.d1 = '0; bus_m.d2 = '0;
        bus_d.sample_valid = 1'b0; bus_d.vfc = '0; bus_d.vout = '0; bus_d.d1 = '0; bus_d.d2 = '0;
        bus_s.sample_valid = 1'b0; bus_s.vfc = '0; bus_s.vout = '0; bus_s.d1 = '0; bus_s.d2 = '0;
        rst_n_m = 1'b0;
        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx_m, 1);
        check("reset_busy", busy_m, 0);
        check("reset_drop", drop_m, 0);
        check("reset_cnt", cnt_m, 0);
        check("reset_dec_tx", tx_d, 1);
        check("reset_dec_busy", busy_d, 0);
        check("reset_sat_tx", tx_s, 1);
        check("reset_sat_cnt", cnt_s, 0);
        rst_n_m = 1'b1;
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;
        fork
            main_thread();
            sat_thread();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
